// File: rtl/hazard_pkg.sv
// Shared constants, FSM state encoding and cell-index helpers for the hazard grid blocks.
// Used by hazard_decoder and hazard_encoder.
package hazard_pkg;

  localparam int ROWS    = 4;
  localparam int COLS    = 8;
  localparam int CELL_W  = 3;
  localparam int CELL_H  = 2;
  localparam int COORD_W = 5;
  localparam int CELLS   = ROWS * COLS;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    GROW_R,
    GROW_D,
    EMIT,
    DONE
  } state_t;

  function automatic logic [4:0] cell_idx(input logic [1:0] r, input logic [2:0] c);
    return 5'(int'(r) * COLS + int'(c));
  endfunction

  function automatic logic [1:0] cell_row(input logic [4:0] k);
    return 2'(int'(k) / COLS);
  endfunction

  function automatic logic [2:0] cell_col(input logic [4:0] k);
    return 3'(int'(k) % COLS);
  endfunction

endpackage

// File: rtl/hazard_cell_to_px.sv
// Combinational conversion of a cell rectangle to inclusive pixel bounds.
// Optional one-pixel clamped margin when HAZARD_DECODER_MARGIN_EN is defined.
module hazard_cell_to_px
  import hazard_pkg::*;
(
  input  logic [1:0]         r0,
  input  logic [2:0]         c0,
  input  logic [1:0]         r1,
  input  logic [2:0]         c1,
  output logic [COORD_W-1:0] top,
  output logic [COORD_W-1:0] left,
  output logic [COORD_W-1:0] bottom,
  output logic [COORD_W-1:0] right
);

  logic [7:0] top_px, left_px, bottom_px, right_px;

  assign top_px    = 8'(r0) * 8'(CELL_H);
  assign left_px   = 8'(c0) * 8'(CELL_W);
  assign bottom_px = (8'(r1) + 8'd1) * 8'(CELL_H) - 8'd1;
  assign right_px  = (8'(c1) + 8'd1) * 8'(CELL_W) - 8'd1;

`ifdef HAZARD_DECODER_MARGIN_EN
  localparam logic [7:0] MAX_BOTTOM = 8'(ROWS * CELL_H - 1);
  localparam logic [7:0] MAX_RIGHT  = 8'(COLS * CELL_W - 1);

  assign top    = (top_px == 8'd0)  ? '0 : COORD_W'(top_px - 8'd1);
  assign left   = (left_px == 8'd0) ? '0 : COORD_W'(left_px - 8'd1);
  assign bottom = (bottom_px >= MAX_BOTTOM) ? COORD_W'(MAX_BOTTOM) : COORD_W'(bottom_px + 8'd1);
  assign right  = (right_px >= MAX_RIGHT)   ? COORD_W'(MAX_RIGHT)  : COORD_W'(right_px + 8'd1);
`else
  assign top    = COORD_W'(top_px);
  assign left   = COORD_W'(left_px);
  assign bottom = COORD_W'(bottom_px);
  assign right  = COORD_W'(right_px);
`endif

endmodule

// File: rtl/hazard_decoder.sv
// Rebuilds pixel bounding boxes from a 4x8 occupancy grid by greedy rectangle growth.
// Optional margin (HAZARD_DECODER_MARGIN_EN) is applied inside hazard_cell_to_px.
module hazard_decoder
  import hazard_pkg::*;
#(
  parameter int MAX_HAZ = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        vec1,
  input  logic [15:0]        vec2,
  output logic               box_valid,
  input  logic               box_ready,
  output logic [COORD_W-1:0] box_top,
  output logic [COORD_W-1:0] box_left,
  output logic [COORD_W-1:0] box_bottom,
  output logic [COORD_W-1:0] box_right,
  output logic [3:0]         box_idx,
  output logic               done,
  output logic [4:0]         num_hazards,
  output logic               overflow
);

  state_t           state_reg, state_next;
  logic [CELLS-1:0] grid_reg;
  logic [5:0]       scan_ptr_reg;
  logic [4:0]       count_reg;
  logic [1:0]       r0_reg, r1_reg;
  logic [2:0]       c0_reg, c1_reg;

  logic             scan_cell, can_grow_r, can_grow_d, at_max;
  logic [COLS-1:0]  below_ok;
  logic [CELLS-1:0] clear_mask;
  logic [COORD_W-1:0] px_top, px_left, px_bottom, px_right;

  assign in_ready  = (state_reg == IDLE);
  assign box_valid = (state_reg == EMIT);
  assign done      = (state_reg == DONE);

  assign scan_cell  = grid_reg[scan_ptr_reg[4:0]];
  assign at_max     = (count_reg == 5'(MAX_HAZ));
  assign can_grow_r = (c1_reg != 3'(COLS - 1)) && grid_reg[cell_idx(r0_reg, c1_reg + 3'd1)];

  // Row below the current rectangle must be fully set across c0..c1.
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_below
      assign below_ok[gi] = !((3'(gi) >= c0_reg) && (3'(gi) <= c1_reg)) ||
                            grid_reg[cell_idx(r1_reg + 2'd1, 3'(gi))];
    end
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_clear
      assign clear_mask[gi] = (cell_row(5'(gi)) >= r0_reg) && (cell_row(5'(gi)) <= r1_reg) &&
                              (cell_col(5'(gi)) >= c0_reg) && (cell_col(5'(gi)) <= c1_reg);
    end
  endgenerate

  assign can_grow_d = (r1_reg != 2'(ROWS - 1)) && (&below_ok);

  hazard_cell_to_px u_px (
    .r0     (r0_reg),
    .c0     (c0_reg),
    .r1     (r1_reg),
    .c1     (c1_reg),
    .top    (px_top),
    .left   (px_left),
    .bottom (px_bottom),
    .right  (px_right)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (in_valid) state_next = SCAN;
      SCAN: begin
        if (scan_ptr_reg[5])              state_next = DONE;
        else if (scan_cell)               state_next = at_max ? DONE : GROW_R;
        else if (scan_ptr_reg == 6'd31)   state_next = DONE;
      end
      GROW_R: if (!can_grow_r) state_next = GROW_D;
      GROW_D: if (!can_grow_d) state_next = EMIT;
      EMIT:   if (box_ready)   state_next = SCAN;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid_reg     <= '0;
      scan_ptr_reg <= '0;
      count_reg    <= '0;
      r0_reg       <= '0;
      r1_reg       <= '0;
      c0_reg       <= '0;
      c1_reg       <= '0;
      box_top      <= '0;
      box_left     <= '0;
      box_bottom   <= '0;
      box_right    <= '0;
      box_idx      <= '0;
      num_hazards  <= '0;
      overflow     <= 1'b0;
    end else begin
      if (state_next == DONE) num_hazards <= count_reg;
      case (state_reg)
        IDLE: if (in_valid) begin
          grid_reg     <= {vec2, vec1};
          scan_ptr_reg <= '0;
          count_reg    <= '0;
          num_hazards  <= '0;
          overflow     <= 1'b0;
        end
        SCAN: if (!scan_ptr_reg[5]) begin
          if (scan_cell) begin
            if (at_max) begin
              overflow <= 1'b1;
            end else begin
              r0_reg <= cell_row(scan_ptr_reg[4:0]);
              c0_reg <= cell_col(scan_ptr_reg[4:0]);
              c1_reg <= cell_col(scan_ptr_reg[4:0]);
            end
          end else begin
            scan_ptr_reg <= scan_ptr_reg + 6'd1;
          end
        end
        GROW_R: begin
          if (can_grow_r) c1_reg <= c1_reg + 3'd1;
          else            r1_reg <= r0_reg;
        end
        GROW_D: begin
          if (can_grow_d) begin
            r1_reg <= r1_reg + 2'd1;
          end else begin
            box_top    <= px_top;
            box_left   <= px_left;
            box_bottom <= px_bottom;
            box_right  <= px_right;
            box_idx    <= count_reg[3:0];
          end
        end
        EMIT: if (box_ready) begin
          grid_reg     <= grid_reg & ~clear_mask;
          count_reg    <= count_reg + 5'd1;
          scan_ptr_reg <= {1'b0, cell_idx(r0_reg, c1_reg)} + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hazard_decoder.md
Name: hazard_decoder

Overview:
- Inverse of hazard_encoder: accepts a 4x8 hazard occupancy grid ({vec2,vec1}) and reconstructs pixel-space bounding boxes (top/left/bottom/right).
- Extracts boxes by sequential greedy rectangle growth and streams them one per valid/ready handshake.
- Sits between the occupancy-map producer and the path planner, which consumes boxes.

Parameters:
- ROWS, 4, grid rows; ROWS*COLS fixed at 32.
- COLS, 8, grid columns.
- CELL_W, 3, pixels per cell horizontally.
- CELL_H, 2, pixels per cell vertically.
- MAX_HAZ, 16, maximum boxes emitted per grid (1..16).
- COORD_W, 5, pixel coordinate width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous active-low reset.
- in_valid  in  1  grid valid.
- in_ready  out  1  high only in IDLE.
- vec1  in  16  cells k=0..15; k=row*8+col; rows 0-1.
- vec2  in  16  cells k=16..31; rows 2-3.
- box_valid  out  1  box available.
- box_ready  in  1  consumer accepts.
- box_top, box_left, box_bottom, box_right  out  COORD_W  inclusive pixel bounds.
- box_idx  out  4  ordinal of current box.
- done  out  1  one-cycle pulse at end of grid.
- num_hazards  out  5  boxes emitted; valid with done, held until next accept.
- overflow  out  1  set cells remained after MAX_HAZ boxes; valid with done.

Behaviour:
- Reset: state IDLE; in_ready=1; box_valid, done, overflow, num_hazards, box_* and box_idx = 0; internal grid cleared.
- Accept: in_valid&&in_ready latches {vec2,vec1} into grid, resets scan_ptr=0 and count=0; next cycle is SCAN.
- SCAN: tests one cell per cycle at scan_ptr.
  - Clear cell: scan_ptr++.
  - scan_ptr reaches 32: DONE.
  - Set cell with count==MAX_HAZ: overflow=1, go to DONE.
  - Otherwise: r0=row, c0=col, c1=c0, go to GROW_R.
- GROW_R: one cycle per column. If c1+1<COLS and cell(r0,c1+1) is set, c1++; else r1=r0 and go to GROW_D.
- GROW_D: one cycle per row. If r1+1<ROWS and all cells (r1+1, c0..c1) are set (combinational mask), r1++; else go to EMIT.
- EMIT: box_valid=1 with:
  - top=r0*CELL_H, left=c0*CELL_W;
  - bottom=(r1+1)*CELL_H-1, right=(c1+1)*CELL_W-1;
  - box_idx=count.
  - Outputs held stable while box_valid && !box_ready.
  - On handshake: clear cells r0..r1 x c0..c1, count++, box_valid=0, scan_ptr=k(r0,c1)+1, return to SCAN.
- DONE: done=1 for one cycle; num_hazards=count; return to IDLE.
- Cleared cells read as unset for all later growth.
- in_valid while not IDLE is ignored; no input is lost silently because in_ready=0.
- Arithmetic is unsigned. Max right=23 and max bottom=7 fit in COORD_W.
- Empty grid: 32 SCAN cycles, then done with num_hazards=0.
- rst_n asserted mid-operation: immediate return to reset state; any partial stream is abandoned.

Optional Feature:
- HAZARD_DECODER_MARGIN_EN.
  - Defined: each emitted box grows by 1 pixel per side, clamped to top/left>=0, right<=COLS*CELL_W-1, bottom<=ROWS*CELL_H-1. The clamp is computed in EMIT with the same timing.
  - Undefined: exact cell bounds, no margin logic.

Decomposition:
- Shared package hazard_pkg:
  - constants ROWS, COLS, CELL_W, CELL_H, COORD_W;
  - state enum (IDLE, SCAN, GROW_R, GROW_D, EMIT, DONE);
  - cell-index/row/col helper functions, shared with hazard_encoder.
- One sub-module, hazard_cell_to_px: combinational r0,c0,r1,c1 -> pixel bounds, with the margin clamp under the macro.

Test Plan:
- Reset then vec1=0, vec2=0 -> no box_valid; done after 32 SCAN cycles; num_hazards=0, overflow=0.
- vec1=16'h0001 -> one box (0,0,1,2), box_idx=0; done, num_hazards=1.
- Cells rows1-3 x cols5-7 (vec1=16'hE000, vec2=16'hE0E0) -> box (top 2, left 15, bottom 7, right 23); num_hazards=1.
- vec1=vec2=16'hFFFF -> single box (0,0,7,23). With HAZARD_DECODER_MARGIN_EN -> same box (clamped).
- Checkerboard vec1=vec2=16'hAA55, box_ready toggling 1/0 -> 16 single-cell boxes in raster order; outputs stable during stalls; num_hazards=16, overflow=0. With MAX_HAZ=4 override -> 4 boxes, overflow=1.
- rst_n pulsed low during EMIT of the 2nd box -> box_valid=0 immediately; in_ready=1. A new grid then decodes correctly.
